serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller that time-shares a single `full_adder` cell across all bits of a WIDTH-bit operand pair. On a `start` pulse it captures both operands, steps the full adder one bit per clock from LSB to MSB with a registered carry, and presents the sum and carry-out with a one-cycle `done` strobe. It is the sequential counterpart to the switch-driven ripple adders on the board, and serves any requester that can wait WIDTH cycles for a result.

## Interface
- `WIDTH`, default 8, operand and sum width in bits; legal range 2..32.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  operand A; sampled on the edge that accepts `start`.
- `b`  input  WIDTH  operand B; sampled on the edge that accepts `start`.
- `sub`  input  1  subtract select; present only when `SERIAL_ADDER_SUB_EN` is defined; sampled with `a`/`b`.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle strobe: `sum`/`cout` valid.
- `sum`  output  WIDTH  result, held until the next accepted `start`.
- `cout`  output  1  final carry out of the MSB, held with `sum`.

## Operation
- Exactly one `full_adder` instance: A = `a_sh[0]`, B = `b_sh[0]`, Cin = `carry`, Y and Cout consumed as below.
- Registers:
  - `a_sh`, `b_sh`: WIDTH-bit operand shift registers.
  - `sum_sh`: WIDTH-bit result shift register.
  - `carry`: 1 bit.
  - `cnt`: $clog2(WIDTH) bits.
  - `state`.
- States: IDLE, RUN, DONE.
  - IDLE, `start`=1:
    - load `a_sh`←`a`, `b_sh`←`b`, `carry`←0, `cnt`←0.
    - go to RUN.
  - IDLE, `start`=0: hold.
  - RUN, every edge:
    - `sum_sh` ← {Y, `sum_sh[WIDTH-1:1]`}.
    - `a_sh`, `b_sh` shift right one bit, zero-filling the MSB.
    - `carry`←Cout, `cnt`←`cnt`+1.
    - When `cnt`==WIDTH-1, also go to DONE.
  - DONE: unconditionally return to IDLE after one cycle.
- `busy` = (state==RUN). `done` = (state==DONE).
- `sum` = `sum_sh`. `cout` = `carry`.
- Result arithmetic: `sum` = (a+b) mod 2^WIDTH; `cout` = bit WIDTH of a+b.
- `start` asserted in RUN or DONE is ignored. It is not queued: the requester must hold or re-assert it.
- `a`/`b` may change freely after the accepting edge.

## Timing
- Reset (async assert, any time, including mid-RUN):
  - state=IDLE, `busy`=0, `done`=0.
  - `sum`=0, `cout`=0, `carry`=0, `cnt`=0, `a_sh`=`b_sh`=0.
  - Any operation in progress is discarded; no `done` follows.
- Reset release: the first rising edge with `rst_n`=1 may accept `start`.
- Let edge E0 accept `start`:
  - `busy` rises after E0.
  - Bit i is added on edge E0+1+i.
  - `busy` falls and `done` rises after E0+WIDTH.
  - `done` falls after E0+WIDTH+1.
- Latency is WIDTH cycles from the accepting edge to `done`.
- Earliest next accept is E0+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- `sum`/`cout` are intermediate (partial) values while `busy`=1. They are final from `done` onward and stable until the next accept.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - `sub` port exists.
  - On accept with `sub`=1: `b_sh`←~`b`, `carry`←1.
  - Result is `sum` = (a−b) mod 2^WIDTH; `cout`=1 means no borrow (a≥b), `cout`=0 means borrow.
  - With `sub`=0, behaviour is identical to the add-only build.
- `SERIAL_ADDER_SUB_EN` undefined: no `sub` port, add-only.
- Timing is identical in both builds.

## Test plan
- WIDTH=8, reset then `start` with a=0x5A, b=0x3C → `done` exactly 8 cycles after the accepting edge, `sum`=0x96, `cout`=0; `busy` high for exactly 8 cycles.
- a=0xFF, b=0x01 → `sum`=0x00, `cout`=1. Then a=0xFF, b=0xFF → `sum`=0xFE, `cout`=1.
- Hold `start`=1 continuously with a=0x01, b=0x02 → an accept every 10 cycles; each `done` carries `sum`=0x03. Change `a` mid-RUN → the current result is unaffected.
- Assert `rst_n`=0 at the 4th RUN cycle → all outputs 0 immediately and no `done` strobe. After release, a=0x10, b=0x20 → `sum`=0x30.
- With `SERIAL_ADDER_SUB_EN`: a=0x10, b=0x01, `sub`=1 → `sum`=0x0F, `cout`=1. Then a=0x01, b=0x02, `sub`=1 → `sum`=0xFF, `cout`=0.
- WIDTH=2 build: a=2'b11, b=2'b01 → `done` 2 cycles after accept, `sum`=2'b00, `cout`=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full_adder steps through a WIDTH-bit operand pair LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic y,
   output logic cout
);

   assign y    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_y;
   logic             fa_cout;
   logic             accept;
   logic             last_bit;
   logic             sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_sel = sub;
`else
   assign sub_sel = 1'b0;
`endif

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .y    (fa_y),
      .cout (fa_cout)
   );

   assign accept   = (state == IDLE) && start;
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: the default assignment first keeps this block purely combinational (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: invert B at load and seed the carry with 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= sub_sel ? ~b : b;
         carry <= sub_sel;
         cnt   <= '0;
      end else if (state == RUN) begin
         sum_sh <= {fa_y, sum_sh[WIDTH-1:1]};
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         carry  <= fa_cout;
         cnt    <= cnt + 1'b1;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign sum  = sum_sh;
   assign cout = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random operations checked
// against an arithmetic reference model, plus a WIDTH=2 instance.

module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   logic         start2 = 1'b0;
   logic [1:0]   a2 = '0;
   logic [1:0]   b2 = '0;
   logic         busy2;
   logic         done2;
   logic [1:0]   sum2;
   logic         cout2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   serial_adder_ctrl #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start2),
      .a     (a2),
      .b     (b2),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (1'b0),
`endif
      .busy  (busy2),
      .done  (done2),
      .sum   (sum2),
      .cout  (cout2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic; returns {cout, sum}.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic s);
      longint unsigned ux = longint'(x);
      longint unsigned uy = longint'(y);
      longint unsigned m  = 64'd1 << W;
      longint unsigned r;
      logic            c;
      if (s) begin
         r = (ux + m - uy) % m;
         c = (ux >= uy);
      end else begin
         r = (ux + uy) % m;
         c = ((ux + uy) >= m);
      end
      return {c, r[W-1:0]};
   endfunction

   // One full transaction from idle: checks latency, busy width, result and done width.
   task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts);
      logic [W:0] exp;
      int k;
      int busy_cnt;
      exp = model(ta, tb_v, ts);
      @(negedge clk);
      start = 1'b1;
      a = ta;
      b = tb_v;
      sub = ts;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      sub = 1'($urandom);
      k = 0;
      busy_cnt = 0;
      while (!done && k < W + 6) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         k++;
      end
      if (!done) begin
         check({tag, "_timeout"}, 64'(done), 64'd1);
      end else begin
         check({tag, "_latency"}, 64'(k), 64'(W));
         check({tag, "_busy_len"}, 64'(busy_cnt), 64'(W));
         check({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
         check({tag, "_cout"}, 64'(cout), 64'(exp[W]));
         @(negedge clk);
         check({tag, "_done_fall"}, 64'({done, busy}), 64'd0);
         check({tag, "_hold"}, 64'({cout, sum}), 64'(exp));
      end
   endtask

   initial begin
      int last_done;
      int n_done;
      int gap_bad;
      int k;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic rs;

      repeat (2) @(negedge clk);
      check("rst_outputs", 64'({busy, done, cout, sum}), 64'd0);
      rst_n = 1'b1;

      do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
      do_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
      do_op("add_ff_ff", 8'hFF, 8'hFF, 1'b0);

      // Continuous start: one accept every W+2 cycles.
      @(negedge clk);
      start = 1'b1;
      a = 8'h01;
      b = 8'h02;
      last_done = -1;
      n_done = 0;
      gap_bad = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done) begin
            check("hold_sum", 64'(sum), 64'h03);
            if (last_done >= 0 && (i - last_done) != W + 2) gap_bad++;
            last_done = i;
            n_done++;
         end
      end
      check("hold_gap_errors", 64'(gap_bad), 64'd0);
      check("hold_enough_dones", 64'(n_done >= 4), 64'd1);
      start = 1'b0;
      repeat (W + 3) @(negedge clk);

      // Reset in the 4th RUN cycle.
      @(negedge clk);
      start = 1'b1;
      a = 8'hAA;
      b = 8'h77;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_reset_outputs", 64'({busy, done, cout, sum}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (done || busy) n_done++;
      end
      check("no_done_after_reset", 64'(n_done), 64'd0);
      do_op("add_10_20", 8'h10, 8'h20, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
      do_op("sub_10_01", 8'h10, 8'h01, 1'b1);
      do_op("sub_01_02", 8'h01, 8'h02, 1'b1);
`endif

      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         do_op($sformatf("rand%0d", i), ra, rb, rs);
      end

      // WIDTH=2 instance.
      @(negedge clk);
      start2 = 1'b1;
      a2 = 2'b11;
      b2 = 2'b01;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      k = 0;
      while (!done2 && k < 8) begin
         @(negedge clk);
         k++;
      end
      check("w2_latency", 64'(k), 64'd2);
      check("w2_sum", 64'(sum2), 64'd0);
      check("w2_cout", 64'(cout2), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
